fifo_write_arbiter: RTL
=======================

Name: fifo_write_arbiter

Overview:
Write-side scheduler for top_async_fifo. It shares the single FIFO write port between N_REQ requesters in the w_clk domain, using round-robin arbitration with bounded bursts. It drives w_en and data_write directly into the FIFO and respects flag_full. Its output side connects straight to the FIFO's w_en, data_write and flag_full ports.

Parameters:
DATAIN_WIDTH, 8, data width of each requester and of the FIFO write port
N_REQ, 4, number of requesters (2..16)
MAX_BURST, 8, maximum beats per grant before forced re-arbitration (1..255)
IDLE_TIMEOUT, 4, consecutive cycles a granted requester may hold valid low before its grant is revoked (1..255)

Ports:
w_clk  in  1  write-domain clock, same clock as the FIFO write side
w_rst  in  1  asynchronous, active-low reset
req_valid  in  N_REQ  per-requester beat valid
req_last  in  N_REQ  per-requester end-of-burst marker, qualified by valid
req_data  in  N_REQ*DATAIN_WIDTH  packed data; requester i occupies bits [i*DATAIN_WIDTH +: DATAIN_WIDTH]
req_ready  out  N_REQ  per-requester accept; at most one bit high
flag_full  in  1  FIFO full flag
w_en  out  1  FIFO write enable
data_write  out  DATAIN_WIDTH  FIFO write data
grant_id  out  $clog2(N_REQ)  current owner; valid while busy=1
busy  out  1  high in BURST state

Behaviour:
- Reset (w_rst=0, asynchronous): state=IDLE, grant_id=0, rr_ptr=N_REQ-1, burst_cnt=0, idle_cnt=0. w_en=0, req_ready=0, busy=0. Reset applied mid-burst drops the burst immediately; no partial beat is written.
- Beat accept (combinational): accept = (state==BURST) & req_valid[grant_id] & ~flag_full. w_en=accept. req_ready[grant_id]=(state==BURST) & ~flag_full. All other req_ready bits are 0. data_write = req_data slice [grant_id]; it is don't-care when w_en=0.
- A beat transfers on a rising edge of w_clk with valid&ready high. There is no output register, so flag_full takes effect on the same cycle it is seen and the FIFO cannot overflow.
- IDLE state:
  - If any req_valid bit is high, select the first set bit searching upward from rr_ptr+1, wrapping modulo N_REQ.
  - Register that index into grant_id, set rr_ptr to it, clear burst_cnt and idle_cnt, and go to BURST.
  - If no req_valid bit is high, stay in IDLE.
  - Arbitration costs one cycle, so the earliest accept is the cycle after a request is seen in IDLE.
- BURST state: evaluated every cycle, in this order.
  1. accept & (req_last[grant_id] | burst_cnt==MAX_BURST-1): go to IDLE.
  2. accept, otherwise: burst_cnt+1; idle_cnt cleared.
  3. ~req_valid[grant_id] & ~flag_full: idle_cnt+1. When idle_cnt==IDLE_TIMEOUT-1, go to IDLE (grant revoked, no beat written).
  4. flag_full: hold. burst_cnt and idle_cnt are unchanged, and full stall never counts toward the timeout.
- Every burst end returns to IDLE, so there is exactly one bubble cycle between bursts. This is the required behaviour.
- Fairness: after a burst by requester k, requester k has lowest priority in the next arbitration. With every requester saturating, grants rotate 0,1,2,...,N_REQ-1,0.
- Counter widths: burst_cnt and idle_cnt are 8 bits. They never wrap because they are bounded by the parameters.
- Simultaneous events:
  - req_last on the MAX_BURST-th beat: single exit, not two.
  - flag_full deasserting on the same cycle valid rises: the beat is accepted.
  - Requests arriving on another port during BURST are ignored until IDLE.
- Requester rule, checked by assertion: once a requester raises valid, it holds valid and data stable until ready. Revocation by timeout applies only to a requester whose valid is low.

Decomposition:
- Package fifo_arb_pkg holds the state enum (IDLE, BURST) and the helper function for the id width ($clog2(N_REQ), minimum 1).
- One sub-module, rr_pick: combinational round-robin priority selector (inputs req vector and rr_ptr; outputs found and index). It is reusable for a future read-side distributor.
- Everything else stays in the top.

Test Plan:
1. Reset mid-burst: requester 2 streams; assert w_rst=0 after 3 beats → w_en=0 and req_ready=0 the same cycle; after release, state=IDLE and rr_ptr=3, so the next grant goes to requester 0 if it is requesting.
2. All 4 requesters saturating, no req_last, MAX_BURST=8, FIFO never full → grants 0,1,2,3,0 with 8 beats each, 1 bubble cycle between bursts, 32 FIFO writes in 36 cycles after the first grant.
3. Requester 1 sends 3 beats with req_last on beat 3 (data 0xA1, 0xA2, 0xA3) → exactly 3 writes in order, then IDLE; requester 2, pending, is granted next.
4. flag_full held high for 5 cycles mid-burst at beat 4 of 8 → w_en=0 for those 5 cycles, burst_cnt frozen at 4, no timeout; the remaining 4 beats complete after flag_full falls.
5. Granted requester 0 drops valid with IDLE_TIMEOUT=4 → the grant is revoked on the 4th idle cycle; requester 3, pending, is granted next; no spurious w_en.
6. Random multi-requester traffic against the real top_async_fifo with a slower r_clk → scoreboard confirms no overflow, no lost or duplicated beats, per-requester order preserved, and at most one req_ready bit high at any time.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and related schedulers.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int unsigned CNT_W = 8;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester-side handshake plus FIFO write-port bundle for the write arbiter.
interface fifo_write_arbiter_if #(
    parameter int unsigned DATAIN_WIDTH = 8,
    parameter int unsigned N_REQ        = 4
);
    localparam int unsigned ID_W = fifo_arb_pkg::id_width(N_REQ);

    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0]              req_last;
    logic [N_REQ*DATAIN_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]              req_ready;
    logic                          flag_full;
    logic                          w_en;
    logic [DATAIN_WIDTH-1:0]       data_write;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;

    modport master (
        output req_valid, req_last, req_data, flag_full,
        input  req_ready, w_en, data_write, grant_id, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, flag_full,
        output req_ready, w_en, data_write, grant_id, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request strictly after i_ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_found_c,
    output logic [ID_W-1:0]  o_idx_c
);

    // Scan from the farthest candidate back to ptr+1 so the nearest one wins.
    always_comb begin
        int cand;
        cand      = 0;
        o_found_c = 1'b0;
        o_idx_c   = '0;
        for (int k = int'(N_REQ); k > 0; k--) begin
            cand = (int'(i_ptr) + k) % int'(N_REQ);
            if (i_req[cand]) begin
                o_found_c = 1'b1;
                o_idx_c   = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded scheduler sharing one FIFO write port among N_REQ requesters.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATAIN_WIDTH = 8,
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned IDLE_TIMEOUT = 4
) (
    input  logic                 w_clk,
    input  logic                 w_rst,
    fifo_write_arbiter_if.slave  arb_bus
);

    localparam int unsigned ID_W = id_width(N_REQ);

    arb_state_t          r_state;
    logic [ID_W-1:0]     r_grant_id;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]    r_burst_cnt;
    logic [CNT_W-1:0]    r_idle_cnt;

    logic                    w_found;
    logic [ID_W-1:0]         w_pick;
    logic                    w_in_burst;
    logic                    w_sel_valid;
    logic                    w_sel_last;
    logic                    w_accept;
    logic                    w_burst_end;
    logic                    w_timeout;
    logic [N_REQ-1:0]        w_ready;
    logic [DATAIN_WIDTH-1:0] w_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .i_req     (arb_bus.req_valid),
        .i_ptr     (r_rr_ptr),
        .o_found_c (w_found),
        .o_idx_c   (w_pick)
    );

    assign w_in_burst  = (r_state == BURST);
    assign w_sel_valid = arb_bus.req_valid[r_grant_id];
    assign w_sel_last  = arb_bus.req_last[r_grant_id];
    assign w_accept    = w_in_burst & w_sel_valid & ~arb_bus.flag_full;
    assign w_burst_end = w_sel_last | (r_burst_cnt == CNT_W'(MAX_BURST - 1));
    assign w_timeout   = (r_idle_cnt == CNT_W'(IDLE_TIMEOUT - 1));

    // Owner's data and ready are steered straight through so full stalls act the same cycle.
    always_comb begin
        w_data  = '0;
        w_ready = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (ID_W'(i) == r_grant_id) begin
                w_data = arb_bus.req_data[i*DATAIN_WIDTH +: DATAIN_WIDTH];
            end
        end
        if (w_in_burst && !arb_bus.flag_full) begin
            w_ready[r_grant_id] = 1'b1;
        end
    end

    assign arb_bus.req_ready  = w_ready;
    assign arb_bus.w_en       = w_accept;
    assign arb_bus.data_write = w_data;
    assign arb_bus.grant_id   = r_grant_id;
    assign arb_bus.busy       = w_in_burst;

    // Arbitration and burst bookkeeping; full stalls freeze both counters.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            r_state     <= IDLE;
            r_grant_id  <= '0;
            r_rr_ptr    <= ID_W'(N_REQ - 1);
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant_id  <= w_pick;
                        r_rr_ptr    <= w_pick;
                        r_burst_cnt <= '0;
                        r_idle_cnt  <= '0;
                        r_state     <= BURST;
                    end
                end
                BURST: begin
                    if (w_accept && w_burst_end) begin
                        r_state <= IDLE;
                    end else if (w_accept) begin
                        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                        r_idle_cnt  <= '0;
                    end else if (!w_sel_valid && !arb_bus.flag_full) begin
                        if (w_timeout) begin
                            r_state <= IDLE;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
